// File: rtl/pe_pool.sv
// pe_pool: multi-channel pooling engine (MAX or SUM over a window of beats).
// Each window yields one result vector on a valid/ready output.
// The input stream is back-pressured while that result is pending.
// Optional build macro PE_POOL_RELU_EN clamps negative output channels to 0.
module pe_pool #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 32,
  parameter int WIN_MAX    = 16,
  localparam int CNT_W     = $clog2(WIN_MAX + 1),
  localparam int ACC_W_RAW = DATA_WIDTH + $clog2(WIN_MAX),
  localparam int ACC_W     = (ACC_W_RAW > DATA_WIDTH) ? ACC_W_RAW : DATA_WIDTH + 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_clear,
  input  logic                           i_cfg_mode,
  input  logic [CNT_W-1:0]               i_cfg_len,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
  input  logic                           i_vld,
  output logic                           o_in_rdy,
  output logic [CHANNELS*ACC_W-1:0]      o_result,
  output logic                           o_vld,
  input  logic                           i_rdy,
  output logic                           o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Most negative DATA_WIDTH value, sign-extended to ACC_W: the MAX identity.
  localparam logic signed [ACC_W-1:0] MAX_ID =
    {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  state_t                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q [CHANNELS];
  logic signed [ACC_W-1:0] acc_d [CHANNELS];
  logic [CHANNELS*ACC_W-1:0] result_q, result_d;
  logic                    vld_q, vld_d;

  logic signed [ACC_W-1:0] data_ext [CHANNELS];
  logic signed [ACC_W-1:0] f_val    [CHANNELS];
  logic signed [ACC_W-1:0] out_val  [CHANNELS];
  logic                    last_beat;
  logic [CNT_W-1:0]        len_norm;

  function automatic logic signed [ACC_W-1:0] identity(input logic mode);
    return mode ? '0 : MAX_ID;
  endfunction

  // Per-channel sign extension, combine function f() and optional output ReLU.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      data_ext[k] = {{(ACC_W - DATA_WIDTH){i_data[k*DATA_WIDTH + DATA_WIDTH - 1]}},
                     i_data[k*DATA_WIDTH +: DATA_WIDTH]};
      if (mode_q) begin
        f_val[k] = acc_q[k] + data_ext[k];
      end else begin
        f_val[k] = (data_ext[k] > acc_q[k]) ? data_ext[k] : acc_q[k];
      end
`ifdef PE_POOL_RELU_EN
      out_val[k] = f_val[k][ACC_W-1] ? '0 : f_val[k];
`else
      out_val[k] = f_val[k];
`endif
    end
  end

  // Window length normalisation: 0 means 1, anything above WIN_MAX saturates.
  always_comb begin
    len_norm = i_cfg_len;
    if (i_cfg_len == '0) begin
      len_norm = CNT_W'(1);
    end else if (i_cfg_len > CNT_W'(WIN_MAX)) begin
      len_norm = CNT_W'(WIN_MAX);
    end
  end

  assign last_beat = (cnt_q == (len_q - CNT_W'(1)));

  // Next-state logic: clear dominates, then IDLE/ACC/OUT sequencing.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    vld_d    = vld_q;

    if (i_clear) begin
      state_d = ST_IDLE;
      vld_d   = 1'b0;
      cnt_d   = '0;
      for (int k = 0; k < CHANNELS; k++) acc_d[k] = identity(mode_q);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_ACC;
            mode_d  = i_cfg_mode;
            len_d   = len_norm;
            cnt_d   = '0;
            for (int k = 0; k < CHANNELS; k++) acc_d[k] = identity(i_cfg_mode);
          end
        end
        ST_ACC: begin
          if (i_vld) begin
            if (last_beat) begin
              for (int k = 0; k < CHANNELS; k++) begin
                result_d[k*ACC_W +: ACC_W] = out_val[k];
              end
              vld_d   = 1'b1;
              state_d = ST_OUT;
            end else begin
              acc_d = f_val;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (vld_q && i_rdy) begin
            vld_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_ACC;
            for (int k = 0; k < CHANNELS; k++) acc_d[k] = identity(mode_q);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      len_q    <= CNT_W'(1);
      cnt_q    <= '0;
      result_q <= '0;
      vld_q    <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) acc_q[k] <= MAX_ID;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      vld_q    <= vld_d;
      acc_q    <= acc_d;
    end
  end

  assign o_in_rdy = (state_q == ST_ACC);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_vld    = vld_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_pe_pool.sv
// Directed bench for pe_pool with DATA_WIDTH=8, CHANNELS=4, WIN_MAX=16 (ACC_W=12).
module tb_pe_pool;

  localparam int DW    = 8;
  localparam int CH    = 4;
  localparam int WMAX  = 16;
  localparam int CNT_W = 5;
  localparam int ACC_W = 12;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_start;
  logic               i_clear;
  logic               i_cfg_mode;
  logic [CNT_W-1:0]   i_cfg_len;
  logic [CH*DW-1:0]   i_data;
  logic               i_vld;
  logic               o_in_rdy;
  logic [CH*ACC_W-1:0] o_result;
  logic               o_vld;
  logic               i_rdy;
  logic               o_busy;

  int vectors = 0;
  int miscompares = 0;

  pe_pool #(
    .DATA_WIDTH(DW),
    .CHANNELS  (CH),
    .WIN_MAX   (WMAX)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_clear   (i_clear),
    .i_cfg_mode(i_cfg_mode),
    .i_cfg_len (i_cfg_len),
    .i_data    (i_data),
    .i_vld     (i_vld),
    .o_in_rdy  (o_in_rdy),
    .o_result  (o_result),
    .o_vld     (o_vld),
    .i_rdy     (i_rdy),
    .o_busy    (o_busy)
  );

  // 100 MHz free-running clock.
  always #5 i_clk = ~i_clk;

  function automatic logic [CH*DW-1:0] beat(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [ACC_W-1:0] res_ch(input int k);
    return o_result[k*ACC_W +: ACC_W];
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_win(input logic mode, input logic [CNT_W-1:0] len);
    i_cfg_mode = mode;
    i_cfg_len  = len;
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic handshake();
    i_rdy = 1'b1;
    tick();
    i_rdy = 1'b0;
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded).
  task automatic send_beat(input logic [CH*DW-1:0] d);
    int   waited;
    logic took;
    i_data = d;
    i_vld  = 1'b1;
    waited = 0;
    took   = 1'b0;
    while (!took && waited < 40) begin
      took = o_in_rdy;
      tick();
      waited++;
    end
    i_vld = 1'b0;
    vectors++;
    if (!took) begin
      $display("[TB] FAIL beat_accept: got not-accepted after %0d cycles, expected accepted", waited);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_clear    = 1'b0;
    i_cfg_mode = 1'b0;
    i_cfg_len  = '0;
    i_data     = '0;
    i_vld      = 1'b0;
    i_rdy      = 1'b0;
    repeat (2) @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    tick();
    vectors++;
    if (o_vld !== 1'b0) begin
      $display("[TB] FAIL reset_vld: got %b expected 0", o_vld); miscompares++;
    end
    vectors++;
    if (o_in_rdy !== 1'b0) begin
      $display("[TB] FAIL reset_in_rdy: got %b expected 0", o_in_rdy); miscompares++;
    end
    vectors++;
    if (o_busy !== 1'b0) begin
      $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); miscompares++;
    end
    vectors++;
    if (o_result !== '0) begin
      $display("[TB] FAIL reset_result: got %h expected 0", o_result); miscompares++;
    end
  endtask

  task automatic test_max();
    logic [ACC_W-1:0] exp_res [CH];
    $display("[TB] MAX window len=4");
    start_win(1'b0, 5'd4);
    vectors++;
    if (o_busy !== 1'b1 || o_in_rdy !== 1'b1) begin
      $display("[TB] FAIL max_enter_acc: got busy=%b in_rdy=%b expected 1/1", o_busy, o_in_rdy); miscompares++;
    end
    send_beat(beat(-5,   -128,  127, -1));
    send_beat(beat(3,    -128, -128, -2));
    send_beat(beat(-128, -128, -128, -3));
    vectors++;
    if (o_vld !== 1'b0) begin
      $display("[TB] FAIL max_early_vld: got %b expected 0", o_vld); miscompares++;
    end
    send_beat(beat(2,    -128, -128, -4));
    exp_res[0] = 12'h003;
    exp_res[1] = 12'hF80;
    exp_res[2] = 12'h07F;
    exp_res[3] = 12'hFFF;
    vectors++;
    if (o_vld !== 1'b1 || o_in_rdy !== 1'b0) begin
      $display("[TB] FAIL max_vld: got vld=%b in_rdy=%b expected 1/0", o_vld, o_in_rdy); miscompares++;
    end
    for (int k = 0; k < CH; k++) begin
      vectors++;
      if (res_ch(k) !== exp_res[k]) begin
        $display("[TB] FAIL max_ch%0d: got %h expected %h", k, res_ch(k), exp_res[k]); miscompares++;
      end
    end
    handshake();
    vectors++;
    if (o_vld !== 1'b0 || o_in_rdy !== 1'b1) begin
      $display("[TB] FAIL max_handshake: got vld=%b in_rdy=%b expected 0/1", o_vld, o_in_rdy); miscompares++;
    end
    pulse_clear();
  endtask

  task automatic test_sum();
    logic [ACC_W-1:0] exp_res [CH];
    $display("[TB] SUM window len=16");
    start_win(1'b1, 5'd16);
    for (int i = 0; i < 16; i++) send_beat(beat(127, -128, 1, i - 8));
    exp_res[0] = 12'h7F0;
    exp_res[1] = 12'h800;
    exp_res[2] = 12'h010;
    exp_res[3] = 12'hFF8;
    vectors++;
    if (o_vld !== 1'b1) begin
      $display("[TB] FAIL sum_vld: got %b expected 1", o_vld); miscompares++;
    end
    for (int k = 0; k < CH; k++) begin
      vectors++;
      if (res_ch(k) !== exp_res[k]) begin
        $display("[TB] FAIL sum_ch%0d: got %h expected %h", k, res_ch(k), exp_res[k]); miscompares++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [CH*ACC_W-1:0] held;
    held = {12'hFF8, 12'h010, 12'h800, 12'h7F0};
    $display("[TB] backpressure on pending SUM result");
    i_rdy  = 1'b0;
    i_data = beat(55, 55, 55, 55);
    i_vld  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (o_vld !== 1'b1 || o_in_rdy !== 1'b0 || o_result !== held) begin
        $display("[TB] FAIL bp_hold_c%0d: got vld=%b in_rdy=%b res=%h expected 1/0/%h",
                 c, o_vld, o_in_rdy, o_result, held);
        miscompares++;
      end
    end
    i_vld = 1'b0;
    handshake();
    vectors++;
    if (o_vld !== 1'b0 || o_in_rdy !== 1'b1 || o_busy !== 1'b1) begin
      $display("[TB] FAIL bp_release: got vld=%b in_rdy=%b busy=%b expected 0/1/1",
               o_vld, o_in_rdy, o_busy);
      miscompares++;
    end
    for (int i = 0; i < 16; i++) send_beat(beat(1, 0, -1, 0));
    vectors++;
    if (o_vld !== 1'b1 || o_result !== {12'h000, 12'hFF0, 12'h000, 12'h010}) begin
      $display("[TB] FAIL bp_next_window: got vld=%b res=%h expected 1/%h",
               o_vld, o_result, {12'h000, 12'hFF0, 12'h000, 12'h010});
      miscompares++;
    end
    handshake();
    pulse_clear();
  endtask

  task automatic test_len_bounds();
    $display("[TB] window length 0 and over-range");
    start_win(1'b0, 5'd0);
    send_beat(beat(-7, 5, -128, 127));
    vectors++;
    if (o_vld !== 1'b1 || o_result !== {12'h07F, 12'hF80, 12'h005, 12'hFF9}) begin
      $display("[TB] FAIL len0_first: got vld=%b res=%h expected 1/%h",
               o_vld, o_result, {12'h07F, 12'hF80, 12'h005, 12'hFF9});
      miscompares++;
    end
    handshake();
    send_beat(beat(-1, 0, 1, 2));
    vectors++;
    if (o_vld !== 1'b1 || o_result !== {12'h002, 12'h001, 12'h000, 12'hFFF}) begin
      $display("[TB] FAIL len0_second: got vld=%b res=%h expected 1/%h",
               o_vld, o_result, {12'h002, 12'h001, 12'h000, 12'hFFF});
      miscompares++;
    end
    handshake();
    pulse_clear();
    start_win(1'b1, 5'd31);
    for (int i = 0; i < 15; i++) send_beat(beat(1, 1, 1, 1));
    vectors++;
    if (o_vld !== 1'b0 || o_in_rdy !== 1'b1) begin
      $display("[TB] FAIL len31_after15: got vld=%b in_rdy=%b expected 0/1", o_vld, o_in_rdy); miscompares++;
    end
    send_beat(beat(1, 1, 1, 1));
    vectors++;
    if (o_vld !== 1'b1 || o_result !== {4{12'h010}}) begin
      $display("[TB] FAIL len31_after16: got vld=%b res=%h expected 1/%h", o_vld, o_result, {4{12'h010}});
      miscompares++;
    end
    handshake();
    pulse_clear();
  endtask

  task automatic test_clear();
    $display("[TB] abort with clear and async reset");
    start_win(1'b1, 5'd4);
    send_beat(beat(10, 10, 10, 10));
    send_beat(beat(10, 10, 10, 10));
    i_data  = beat(10, 10, 10, 10);
    i_vld   = 1'b1;
    i_clear = 1'b1;
    i_start = 1'b1;
    tick();
    i_vld   = 1'b0;
    i_clear = 1'b0;
    i_start = 1'b0;
    vectors++;
    if (o_vld !== 1'b0 || o_busy !== 1'b0 || o_in_rdy !== 1'b0) begin
      $display("[TB] FAIL clear_mid: got vld=%b busy=%b in_rdy=%b expected 0/0/0", o_vld, o_busy, o_in_rdy);
      miscompares++;
    end
    vectors++;
    if (o_result !== {4{12'h010}}) begin
      $display("[TB] FAIL clear_result_kept: got %h expected %h", o_result, {4{12'h010}}); miscompares++;
    end
    start_win(1'b1, 5'd4);
    for (int i = 1; i <= 4; i++) send_beat(beat(i, -i, 0, 2 * i));
    vectors++;
    if (o_vld !== 1'b1 || o_result !== {12'h014, 12'h000, 12'hFF6, 12'h00A}) begin
      $display("[TB] FAIL clear_fresh: got vld=%b res=%h expected 1/%h",
               o_vld, o_result, {12'h014, 12'h000, 12'hFF6, 12'h00A});
      miscompares++;
    end
    handshake();
    pulse_clear();
    start_win(1'b1, 5'd1);
    i_data  = beat(99, 99, 99, 99);
    i_vld   = 1'b1;
    i_clear = 1'b1;
    tick();
    i_vld   = 1'b0;
    i_clear = 1'b0;
    tick();
    vectors++;
    if (o_vld !== 1'b0 || o_busy !== 1'b0 || o_result !== {12'h014, 12'h000, 12'hFF6, 12'h00A}) begin
      $display("[TB] FAIL clear_final_beat: got vld=%b busy=%b res=%h expected 0/0/%h",
               o_vld, o_busy, o_result, {12'h014, 12'h000, 12'hFF6, 12'h00A});
      miscompares++;
    end
    start_win(1'b0, 5'd4);
    send_beat(beat(1, 2, 3, 4));
    send_beat(beat(1, 2, 3, 4));
    #3;
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if (o_vld !== 1'b0 || o_in_rdy !== 1'b0 || o_busy !== 1'b0 || o_result !== '0) begin
      $display("[TB] FAIL async_reset: got vld=%b in_rdy=%b busy=%b res=%h expected 0/0/0/0",
               o_vld, o_in_rdy, o_busy, o_result);
      miscompares++;
    end
    #2;
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_relu();
    logic [ACC_W-1:0] exp_ch0;
`ifdef PE_POOL_RELU_EN
    exp_ch0 = 12'h000;
`else
    exp_ch0 = 12'hFFD;
`endif
    $display("[TB] MAX window of negatives, output ReLU option");
    start_win(1'b0, 5'd3);
    send_beat(beat(-9, 5, 0, -100));
    send_beat(beat(-3, 1, 0, -50));
    send_beat(beat(-7, 2, 0, -60));
    vectors++;
    if (o_vld !== 1'b1 || res_ch(0) !== exp_ch0 || res_ch(1) !== 12'h005) begin
      $display("[TB] FAIL relu_max: got vld=%b ch0=%h ch1=%h expected 1/%h/005",
               o_vld, res_ch(0), res_ch(1), exp_ch0);
      miscompares++;
    end
    handshake();
    pulse_clear();
  endtask

  initial begin
    test_reset();
    test_max();
    test_sum();
    test_backpressure();
    test_len_bounds();
    test_clear();
    test_relu();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
